// File: rtl/drv_pkg.sv
// Shared types for the three-phase gate-drive stage: phase selection codes,
// per-leg FSM states and the target decode used by every leg.
package drv_pkg;

  typedef enum logic [1:0] {
    SEL_OFF   = 2'b00,
    SEL_FWD   = 2'b01,
    SEL_REV   = 2'b10,
    SEL_BRAKE = 2'b11
  } phase_sel_t;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    DEAD  = 2'b01,
    HI_ON = 2'b10,
    LO_ON = 2'b11
  } leg_state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'b00,
    TGT_HI   = 2'b01,
    TGT_LO   = 2'b10
  } leg_target_t;

  localparam int DEAD_CYC_DEF = 32;

  // Brake only ever closes the low switch; the PWM off-time lets the leg float.
  function automatic leg_target_t legTarget(input logic en, input phase_sel_t sel,
                                            input logic pwmSig);
    leg_target_t t;
    t = TGT_NONE;
    if (en) begin
      case (sel)
        SEL_FWD:   t = pwmSig ? TGT_HI : TGT_LO;
        SEL_REV:   t = pwmSig ? TGT_LO : TGT_HI;
        SEL_BRAKE: t = pwmSig ? TGT_LO : TGT_NONE;
        default:   t = TGT_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/nonoverlap_leg.sv
// One half-bridge leg: target decode, dead-time FSM and registered gate enables.
// Both switches are guaranteed off for DEAD_CYC clocks after either turns off.
module nonoverlap_leg
  import drv_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       pwmSig_i,
  input  logic [1:0] sel_i,
  output logic       high_o,
  output logic       low_o
);

  localparam int CW = $clog2(DEAD_CYC + 1);
  localparam logic [CW-1:0] DCNT_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] DCNT_MAX  = CW'(DEAD_CYC);

  leg_target_t   target;
  leg_state_t    state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          high_q, low_q;

  assign target = legTarget(en_i, phase_sel_t'(sel_i), pwmSig_i);

  // The dead counter is only cleared on a turn-off, so retargeting while in
  // DEAD keeps counting from the last switch opening.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      OFF: begin
        if (target != TGT_NONE) begin
          state_d = DEAD;
          dcnt_d  = '0;
        end
      end
      HI_ON: begin
        if (target != TGT_HI) begin
          state_d = DEAD;
          dcnt_d  = '0;
        end
      end
      LO_ON: begin
        if (target != TGT_LO) begin
          state_d = DEAD;
          dcnt_d  = '0;
        end
      end
      DEAD: begin
        if (target == TGT_NONE) begin
          state_d = OFF;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = (target == TGT_HI) ? HI_ON : LO_ON;
        end else if (dcnt_q != DCNT_MAX) begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Gate enables are flopped from the next state so they leave straight from
  // a register and switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      dcnt_q  <= '0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      high_q  <= (state_d == HI_ON);
      low_q   <= (state_d == LO_ON);
    end
  end

  assign high_o = high_q;
  assign low_o  = low_q;

endmodule

// File: rtl/mtr_gate_drv.sv
// Three-phase gate-drive stage: latches the commutation selection once per PWM
// period and feeds it to three independent non-overlap legs.
module mtr_gate_drv
  import drv_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PWM_sig,
  input  logic       PWM_synch,
  input  logic       en,
  input  logic [1:0] selU,
  input  logic [1:0] selV,
  input  logic [1:0] selW,
  output logic       highU,
  output logic       lowU,
  output logic       highV,
  output logic       lowV,
  output logic       highW,
  output logic       lowW
);

  phase_sel_t selU_q, selV_q, selW_q;

  // Selection only changes at a period boundary so commutation never splits a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selU_q <= SEL_OFF;
      selV_q <= SEL_OFF;
      selW_q <= SEL_OFF;
    end else if (PWM_synch) begin
      selU_q <= phase_sel_t'(selU);
      selV_q <= phase_sel_t'(selV);
      selW_q <= phase_sel_t'(selW);
    end
  end

  nonoverlap_leg #(.DEAD_CYC(DEAD_CYC)) uLegU (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .pwmSig_i(PWM_sig),
    .sel_i   (selU_q),
    .high_o  (highU),
    .low_o   (lowU)
  );

  nonoverlap_leg #(.DEAD_CYC(DEAD_CYC)) uLegV (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .pwmSig_i(PWM_sig),
    .sel_i   (selV_q),
    .high_o  (highV),
    .low_o   (lowV)
  );

  nonoverlap_leg #(.DEAD_CYC(DEAD_CYC)) uLegW (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .pwmSig_i(PWM_sig),
    .sel_i   (selW_q),
    .high_o  (highW),
    .low_o   (lowW)
  );

endmodule

// File: tb/tb_mtr_gate_drv.sv
// Self-checking bench for mtr_gate_drv with DEAD_CYC=4: a behavioural leg model
// feeds a scoreboard each clock, plus directed latency and reset checks.
module tb_mtr_gate_drv;
  import drv_pkg::*;

  localparam int DC     = 4;
  localparam int PERIOD = 2048;
  localparam int T_NONE = 0, T_HI = 1, T_LO = 2;
  localparam int M_OFF = 0, M_DEAD = 1, M_HI = 2, M_LO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PWM_sig = 1'b0, PWM_synch = 1'b0, en = 1'b0;
  logic [1:0] selU = 2'b00, selV = 2'b00, selW = 2'b00;
  logic highU, lowU, highV, lowV, highW, lowW;

  mtr_gate_drv #(.DEAD_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .PWM_sig(PWM_sig), .PWM_synch(PWM_synch), .en(en),
    .selU(selU), .selV(selV), .selW(selW),
    .highU(highU), .lowU(lowU), .highV(highV), .lowV(lowV), .highW(highW), .lowW(lowW)
  );

  always #5 clk = ~clk;

  int nVec = 0, nErr = 0;
  logic [5:0] expQ[$];
  int mState[3], mCnt[3], mSel[3];
  int pwmCnt = 0, duty = 1024, edgeN = 0;
  logic prevSig = 1'b0;
  logic [5:0] prevObs = '0;
  int sigRiseEdge = 0, sigFallEdge = 0, synchEdge = 0;
  int hiRise[3], hiFall[3], loRise[3], loFall[3], hiCount[3], loCount[3];
  int firstOn[3] = '{-1, -1, -1};

  function automatic logic [5:0] gates();
    return {highU, lowU, highV, lowV, highW, lowW};
  endfunction

  function automatic int modelTarget(logic e, int sel, logic sig);
    if (!e) return T_NONE;
    case (sel)
      1: return sig ? T_HI : T_LO;
      2: return sig ? T_LO : T_HI;
      3: return sig ? T_LO : T_NONE;
      default: return T_NONE;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mState[i] = M_OFF;
      mCnt[i]   = 0;
      mSel[i]   = 0;
    end
  endtask

  // Predicts the gate vector right after the coming edge from the inputs now driven.
  task automatic modelStep(output logic [5:0] g);
    int t;
    g = '0;
    for (int i = 0; i < 3; i++) begin
      t = modelTarget(en, mSel[i], PWM_sig);
      case (mState[i])
        M_OFF: if (t != T_NONE) begin mState[i] = M_DEAD; mCnt[i] = 0; end
        M_HI:  if (t != T_HI)   begin mState[i] = M_DEAD; mCnt[i] = 0; end
        M_LO:  if (t != T_LO)   begin mState[i] = M_DEAD; mCnt[i] = 0; end
        default: begin
          if (t == T_NONE) mState[i] = M_OFF;
          else if (mCnt[i] >= DC - 1) mState[i] = (t == T_HI) ? M_HI : M_LO;
          else mCnt[i]++;
        end
      endcase
      g[5-2*i] = (mState[i] == M_HI);
      g[4-2*i] = (mState[i] == M_LO);
    end
    if (PWM_synch) begin
      mSel[0] = int'(selU);
      mSel[1] = int'(selV);
      mSel[2] = int'(selW);
    end
  endtask

  task automatic checkVal(input string tag, input int obs, input int exp);
    nVec++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [5:0] obs, exp;
    logic h, l, ph, pl;
    obs = gates();
    exp = expQ.pop_front();
    nVec++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("[TB] FAIL gates@edge%0d: observed %b expected %b", edgeN, obs, exp);
    end
    for (int i = 0; i < 3; i++) begin
      h  = obs[5-2*i];
      l  = obs[4-2*i];
      ph = prevObs[5-2*i];
      pl = prevObs[4-2*i];
      if (h && !ph) hiRise[i] = edgeN;
      if (!h && ph) hiFall[i] = edgeN;
      if (l && !pl) loRise[i] = edgeN;
      if (!l && pl) loFall[i] = edgeN;
      if (h) hiCount[i]++;
      if (l) loCount[i]++;
      if (firstOn[i] < 0 && (h || l)) firstOn[i] = edgeN;
    end
    prevObs = obs;
  endtask

  // Acts as the PWM generator: inputs change 1 time unit after an edge, like a
  // registered source, and the model's prediction is queued for the next edge.
  task automatic applyStimulus();
    logic [5:0] g;
    PWM_sig   = (duty != 0) && (pwmCnt <= duty);
    PWM_synch = (pwmCnt == 0);
    if (PWM_sig && !prevSig) sigRiseEdge = edgeN;
    if (!PWM_sig && prevSig) sigFallEdge = edgeN;
    if (PWM_synch) synchEdge = edgeN + 1;
    prevSig = PWM_sig;
    pwmCnt = (pwmCnt + 1) % PERIOD;
    modelStep(g);
    expQ.push_back(g);
    @(posedge clk);
    edgeN++;
    #1;
    checkOutput();
  endtask

  task automatic runN(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic runTo(input int c);
    while (pwmCnt != c) applyStimulus();
  endtask

  // Whole-run invariants: no shoot-through and no re-turn-on inside the dead time.
  int nN = 0;
  int lastFall[3] = '{-1000, -1000, -1000};
  logic [5:0] monPrev = '0;
  always @(negedge clk) begin : invMon
    logic [5:0] cur;
    logic h, l, rose, fell;
    nN++;
    if (rst_n) begin
      cur = gates();
      for (int i = 0; i < 3; i++) begin
        h = cur[5-2*i];
        l = cur[4-2*i];
        nVec++;
        assert (!(h && l))
        else begin
          nErr++;
          $error("[TB] FAIL overlap leg%0d: high %b low %b, required not both", i, h, l);
        end
        rose = (h && !monPrev[5-2*i]) || (l && !monPrev[4-2*i]);
        fell = (!h && monPrev[5-2*i]) || (!l && monPrev[4-2*i]);
        if (rose) begin
          nVec++;
          assert (nN - lastFall[i] >= DC)
          else begin
            nErr++;
            $error("[TB] FAIL deadtime leg%0d: gap %0d required >= %0d", i, nN - lastFall[i], DC);
          end
        end
        if (fell) lastFall[i] = nN;
      end
      monPrev = cur;
    end
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("resetGates", int'(gates()), 0);
    checkVal("resetStateU", int'(dut.uLegU.state_q), int'(OFF));
    rst_n = 1'b1;
    en    = 1'b1;

    $display("[TB] all selections off");
    runN(20);
    checkVal("selOffGates", int'(gates()), 0);

    $display("[TB] forward drive on U");
    selU = SEL_FWD;
    runTo(0);
    runN(2 * PERIOD);
    checkVal("fwdHiRise", hiRise[0] - sigRiseEdge, DC + 1);
    checkVal("fwdHiFall", hiFall[0] - sigFallEdge, 1);
    checkVal("fwdLoRise", loRise[0] - sigFallEdge, DC + 1);
    checkVal("fwdLoFall", loFall[0] - sigRiseEdge, 1);

    $display("[TB] reverse selection on V changed mid-period");
    runTo(1000);
    selV = SEL_REV;
    firstOn[1] = -1;
    runTo(0);
    checkVal("revHeldOff", firstOn[1], -1);
    runN(PERIOD);
    checkVal("revLatchDelay", firstOn[1] - synchEdge, DC + 1);

    $display("[TB] short pulse");
    duty = 2;
    hiCount[0] = 0;
    loCount[1] = 0;
    runN(PERIOD);
    checkVal("shortPulseHighU", hiCount[0], 0);
    checkVal("shortPulseLowV", loCount[1], 0);

    $display("[TB] brake on W");
    duty = 1024;
    selW = SEL_BRAKE;
    hiCount[2] = 0;
    runN(2 * PERIOD);
    checkVal("brakeHighW", hiCount[2], 0);
    checkVal("brakeLoRise", loRise[2] - sigRiseEdge, DC + 1);
    checkVal("brakeLoFall", loFall[2] - sigFallEdge, 1);

    $display("[TB] enable drop");
    runTo(1500);
    checkVal("enDropPreLowU", int'(lowU), 1);
    en = 1'b0;
    applyStimulus();
    checkVal("enDropLowU", int'(lowU), 0);
    checkVal("enDropStateDead", int'(dut.uLegU.state_q), int'(DEAD));
    applyStimulus();
    checkVal("enDropStateOff", int'(dut.uLegU.state_q), int'(OFF));
    checkVal("enDropGates", int'(gates()), 0);
    runN(10);
    en = 1'b1;
    runTo(100);
    checkVal("preResetHighU", int'(highU), 1);

    $display("[TB] asynchronous reset during HI_ON");
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("asyncRstHighU", int'(highU), 0);
    checkVal("asyncRstGates", int'(gates()), 0);
    modelReset();
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runN(50);
    checkVal("postRstSelOff", int'(gates()), 0);
    runTo(0);
    runN(200);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/mtr_gate_drv.md
# mtr_gate_drv

Three-phase gate-drive stage downstream of the PWM generator. Consumes `PWM_sig` and `PWM_synch`, applies a per-phase commutation selection latched once per PWM period, and produces six high-/low-side gate enables. A dead-time FSM per phase guarantees the two switches of a leg are never on together and never turn on within `DEAD_CYC` clocks of either switch turning off.

## Interface
- `DEAD_CYC`, default 32: dead-time length in clk cycles. Legal range is 1..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PWM_sig`  in  1  registered PWM waveform from the PWM generator.
- `PWM_synch`  in  1  one-cycle pulse, once per 2048-cycle PWM period.
- `en`  in  1  drive enable. Low forces all legs off immediately, with no wait for synch.
- `selU`, `selV`, `selW`  in  2 each  per-phase drive selection (`phase_sel_t`).
- `highU`, `lowU`, `highV`, `lowV`, `highW`, `lowW`  out  1 each  gate enables. Each is driven directly by a flop, with no combinational decode.

## Operation
- **Selection latch.**
  - `sel*` inputs are captured into `sel*_q` on a clk edge where `PWM_synch`=1. They are ignored at every other edge.
  - Reset value of `sel*_q` is `SEL_OFF`.
- **Target per phase,** computed combinationally from `en`, `sel*_q` and `PWM_sig`:
  - `en`=0, or `SEL_OFF`: target is NONE.
  - `SEL_FWD`: target is HI when `PWM_sig`=1, otherwise LO.
  - `SEL_REV`: target is LO when `PWM_sig`=1, otherwise HI.
  - `SEL_BRAKE`: target is LO when `PWM_sig`=1, otherwise NONE.
- **Per-phase FSM.** States are OFF, DEAD, HI_ON, LO_ON. `high`=1 only in HI_ON; `low`=1 only in LO_ON.
  - OFF: if target ≠ NONE, go to DEAD and clear `dcnt`. Otherwise stay.
  - HI_ON: if target ≠ HI, go to DEAD and clear `dcnt`.
  - LO_ON: if target ≠ LO, go to DEAD and clear `dcnt`.
  - DEAD:
    - If target = NONE, go to OFF.
    - Else if `dcnt` = `DEAD_CYC`-1, go to HI_ON or LO_ON per the current target.
    - Else increment `dcnt`.
    - A target change during DEAD does not restart `dcnt`, because dead time is measured from the last turn-off.
  - Direct HI_ON↔LO_ON transitions are illegal.
- **Counter.** `dcnt` width is `$clog2(DEAD_CYC+1)`. It saturates and never wraps.
- **Invariants** (all legs, all cycles):
  - `high` & `low` = 0.
  - After any gate enable falls, no gate enable of that leg rises for at least `DEAD_CYC` cycles.

## Timing
- **Reset.** All outputs are 0, all FSMs are in OFF, `dcnt`=0, and `sel*_q`=`SEL_OFF`. This holds asynchronously on `rst_n` low, including mid-DEAD or mid-ON.
- **Turn-off latency.** The target changes combinationally in cycle t. The active enable falls at edge t+1.
- **Turn-on latency** from entering DEAD at edge t+1: the new side rises at edge t+1+`DEAD_CYC`.
- **Selection latency.** `PWM_synch` high at edge s latches the new selection. The resulting target is first acted on at edge s+1.
- **Simultaneous events.**
  - `PWM_synch` together with a `PWM_sig` edge: the FSM at that edge uses the old `sel*_q`.
  - `en` falling overrides everything. The enable falls at the next edge, and the FSM goes to DEAD and then OFF.
- **Short pulses.** A `PWM_sig` pulse shorter than `DEAD_CYC` never turns on the requested side, and the output stays 0. This is the required behaviour; there is no minimum-pulse stretching.

## Structure
- **Package `drv_pkg`:**
  - `typedef enum logic [1:0] phase_sel_t {SEL_OFF=2'b00, SEL_FWD=2'b01, SEL_REV=2'b10, SEL_BRAKE=2'b11}`.
  - `typedef enum` for the FSM states: OFF, DEAD, HI_ON, LO_ON.
  - `localparam DEAD_CYC_DEF = 32`.
- **Sub-module `nonoverlap_leg`.** Holds the target decode, FSM, `dcnt` and output flops for one phase. It is instantiated three times.
- **Top level.** Holds only the selection latch and the three instances.

## Test plan
All scenarios use `DEAD_CYC`=4 and a PWM generator driving `PWM_sig` and `PWM_synch`.
1. **Reset state.** Reset, then hold `en`=1 with all `sel`=`SEL_OFF` → all six outputs are 0. Assert `rst_n` low mid-HI_ON → `highU` falls asynchronously.
2. **Forward drive.** `selU`=`SEL_FWD`, duty=1024 → `highU` rises 5 clocks after the `PWM_sig` rise and falls 1 clock after the `PWM_sig` fall. `lowU` is the mirror image. Both are 0 for 4 cycles around each edge.
3. **Selection latch timing.** Change `selV` from `SEL_OFF` to `SEL_REV` mid-period → the outputs stay 0 until the edge after the next `PWM_synch`. Then `lowV` follows `PWM_sig` with the dead-time rule above.
4. **Short pulse.** duty=2, giving a 3-cycle `PWM_sig` pulse, with `SEL_FWD` → `highU` never asserts.
5. **Brake mode.** `selW`=`SEL_BRAKE` → `highW` is always 0, and `lowW` follows `PWM_sig`-high delayed by 5 cycles.
6. **Enable drop and invariant.** Drop `en` while `lowU`=1 → `lowU` is 0 at the next edge and the FSM reaches OFF 1 cycle later. An assertion checks the invariants for the whole run.
